// File: rtl/switch_pkg.sv
// Shared types, constants and the round-robin helper used by switch_4port.
package switch_pkg;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned DATA_W    = 8;

    typedef struct packed {
        logic [1:0]           source;
        logic [NUM_PORTS-1:0] target;
        logic [DATA_W-1:0]    data;
    } packet_t;

    // First requester at or after ptr, wrapping; returns ptr when nothing requests.
    function automatic logic [1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                           input logic [1:0]           ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/port_if.sv
// Per-port bundle between the switch and one attached agent.
interface port_if #(
    parameter int unsigned DATA_W = switch_pkg::DATA_W
) (
    input logic clk,
    input logic rst_n
);
    logic              valid_in;
    logic [1:0]        source_in;
    logic [3:0]        target_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [1:0]        source_out;
    logic [3:0]        target_out;
    logic [DATA_W-1:0] data_out;

    modport sw (
        input  clk, rst_n, valid_in, source_in, target_in, data_in,
        output valid_out, source_out, target_out, data_out
    );
endinterface

// File: rtl/port_fifo.sv
// Synchronous packet FIFO with occupancy count; full/empty decode from the count.
module port_fifo
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  packet_t                wdata_i,
    output packet_t                rdata_o,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    packet_t         mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign fifo_count = count_q;
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign rdata_o    = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !fifo_full;
        do_pop   = pop_i && !fifo_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/switch_port.sv
// Ingress side of one port: FIFO plus the head's outstanding-target mask.
module switch_port
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [1:0]           source_i,
    input  logic [NUM_PORTS-1:0] target_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [NUM_PORTS-1:0] clear_i,
    output packet_t              head_o,
    output logic [NUM_PORTS-1:0] pending_o
);
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [NUM_PORTS-1:0]   served_q, served_d;
    logic [NUM_PORTS-1:0]   remaining;
    logic                   push, pop;
    packet_t                wdata;

    assign wdata = '{source: source_i, target: target_i, data: data_i};

    // served_q records outputs already given the head; pending = target minus served.
    always_comb begin
        push      = valid_i && (target_i != '0) && !fifo_full;
        pending_o = (fifo_count != '0) ? (head_o.target & ~served_q) : '0;
        remaining = pending_o & ~clear_i;
        pop       = !fifo_empty && ((clear_i & pending_o) != '0) && (remaining == '0);
        served_d  = pop ? '0 : (served_q | (clear_i & pending_o));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

    port_fifo #(
        .DEPTH(DEPTH)
    ) port_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   (wdata),
        .rdata_o   (head_o),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count)
    );
endmodule

// File: rtl/switch_4port.sv
// Four-port multicast switch: per-port ingress FIFOs, per-output round-robin
// arbiters and a registered crossbar.
module switch_4port
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = switch_pkg::DEPTH
) (
    input logic clk,
    input logic rst_n,
    port_if.sw  port0,
    port_if.sw  port1,
    port_if.sw  port2,
    port_if.sw  port3
);
    logic [NUM_PORTS-1:0] valid_in;
    logic [1:0]           source_in [NUM_PORTS];
    logic [NUM_PORTS-1:0] target_in [NUM_PORTS];
    logic [DATA_W-1:0]    data_in   [NUM_PORTS];
    packet_t              head      [NUM_PORTS];
    logic [NUM_PORTS-1:0] pending   [NUM_PORTS];
    logic [NUM_PORTS-1:0] clear     [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_out_q, valid_out_d;
    packet_t              out_q [NUM_PORTS];
    packet_t              out_d [NUM_PORTS];
    logic [1:0]           ptr_q [NUM_PORTS];
    logic [1:0]           ptr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [1:0]           gnt;

    assign valid_in[0]  = port0.valid_in;
    assign valid_in[1]  = port1.valid_in;
    assign valid_in[2]  = port2.valid_in;
    assign valid_in[3]  = port3.valid_in;
    assign source_in[0] = port0.source_in;
    assign source_in[1] = port1.source_in;
    assign source_in[2] = port2.source_in;
    assign source_in[3] = port3.source_in;
    assign target_in[0] = port0.target_in;
    assign target_in[1] = port1.target_in;
    assign target_in[2] = port2.target_in;
    assign target_in[3] = port3.target_in;
    assign data_in[0]   = port0.data_in;
    assign data_in[1]   = port1.data_in;
    assign data_in[2]   = port2.data_in;
    assign data_in[3]   = port3.data_in;

    switch_port #(.DEPTH(DEPTH)) port0_i (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_in[0]), .source_i(source_in[0]),
        .target_i(target_in[0]), .data_i(data_in[0]), .clear_i(clear[0]),
        .head_o(head[0]), .pending_o(pending[0])
    );
    switch_port #(.DEPTH(DEPTH)) port1_i (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_in[1]), .source_i(source_in[1]),
        .target_i(target_in[1]), .data_i(data_in[1]), .clear_i(clear[1]),
        .head_o(head[1]), .pending_o(pending[1])
    );
    switch_port #(.DEPTH(DEPTH)) port2_i (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_in[2]), .source_i(source_in[2]),
        .target_i(target_in[2]), .data_i(data_in[2]), .clear_i(clear[2]),
        .head_o(head[2]), .pending_o(pending[2])
    );
    switch_port #(.DEPTH(DEPTH)) port3_i (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_in[3]), .source_i(source_in[3]),
        .target_i(target_in[3]), .data_i(data_in[3]), .clear_i(clear[3]),
        .head_o(head[3]), .pending_o(pending[3])
    );

    // Output j arbitrates over the heads still owing it a copy; the grant both
    // loads the output register and clears that head's pending bit j.
    always_comb begin
        valid_out_d = '0;
        out_d       = '{default: '0};
        ptr_d       = ptr_q;
        clear       = '{default: '0};
        req         = '0;
        gnt         = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = pending[i][j];
            end
            gnt = rr_pick(req, ptr_q[j]);
            if (req != '0) begin
                valid_out_d[j] = 1'b1;
                out_d[j]       = head[gnt];
                ptr_d[j]       = gnt + 2'd1;
                clear[gnt][j]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_q <= '0;
            out_q       <= '{default: '0};
            ptr_q       <= '{default: '0};
        end else begin
            valid_out_q <= valid_out_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
        end
    end

    assign port0.valid_out  = valid_out_q[0];
    assign port1.valid_out  = valid_out_q[1];
    assign port2.valid_out  = valid_out_q[2];
    assign port3.valid_out  = valid_out_q[3];
    assign port0.source_out = out_q[0].source;
    assign port1.source_out = out_q[1].source;
    assign port2.source_out = out_q[2].source;
    assign port3.source_out = out_q[3].source;
    assign port0.target_out = out_q[0].target;
    assign port1.target_out = out_q[1].target;
    assign port2.target_out = out_q[2].target;
    assign port3.target_out = out_q[3].target;
    assign port0.data_out   = out_q[0].data;
    assign port1.data_out   = out_q[1].data;
    assign port2.data_out   = out_q[2].data;
    assign port3.data_out   = out_q[3].data;
endmodule

// File: tb/tb_switch_4port.sv
// Directed bench for switch_4port with a transaction-level model feeding a
// per-cycle scoreboard of expected outputs and FIFO occupancies.
module tb_switch_4port;
    import switch_pkg::*;

    typedef struct packed {
        logic    valid;
        packet_t pkt;
    } out_t;
    typedef out_t [3:0] cyc_t;
    typedef struct packed {
        packet_t    pkt;
        logic [3:0] pend;
    } ment_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_if p0 (.clk(clk), .rst_n(rst_n));
    port_if p1 (.clk(clk), .rst_n(rst_n));
    port_if p2 (.clk(clk), .rst_n(rst_n));
    port_if p3 (.clk(clk), .rst_n(rst_n));

    switch_4port dut (
        .clk  (clk),
        .rst_n(rst_n),
        .port0(p0),
        .port1(p1),
        .port2(p2),
        .port3(p3)
    );

    logic [3:0] vin;
    logic [1:0] sin [4];
    logic [3:0] tin [4];
    logic [7:0] din [4];
    out_t       obs [4];
    logic [3:0] cnt [4];

    assign p0.valid_in = vin[0];
    assign p1.valid_in = vin[1];
    assign p2.valid_in = vin[2];
    assign p3.valid_in = vin[3];
    assign p0.source_in = sin[0];
    assign p1.source_in = sin[1];
    assign p2.source_in = sin[2];
    assign p3.source_in = sin[3];
    assign p0.target_in = tin[0];
    assign p1.target_in = tin[1];
    assign p2.target_in = tin[2];
    assign p3.target_in = tin[3];
    assign p0.data_in = din[0];
    assign p1.data_in = din[1];
    assign p2.data_in = din[2];
    assign p3.data_in = din[3];

    assign obs[0] = {p0.valid_out, p0.source_out, p0.target_out, p0.data_out};
    assign obs[1] = {p1.valid_out, p1.source_out, p1.target_out, p1.data_out};
    assign obs[2] = {p2.valid_out, p2.source_out, p2.target_out, p2.data_out};
    assign obs[3] = {p3.valid_out, p3.source_out, p3.target_out, p3.data_out};

    assign cnt[0] = dut.port0_i.port_fifo.fifo_count;
    assign cnt[1] = dut.port1_i.port_fifo.fifo_count;
    assign cnt[2] = dut.port2_i.port_fifo.fifo_count;
    assign cnt[3] = dut.port3_i.port_fifo.fifo_count;

    logic [3:0] full_flags, empty_flags;
    assign full_flags  = {dut.port3_i.port_fifo.fifo_full, dut.port2_i.port_fifo.fifo_full,
                          dut.port1_i.port_fifo.fifo_full, dut.port0_i.port_fifo.fifo_full};
    assign empty_flags = {dut.port3_i.port_fifo.fifo_empty, dut.port2_i.port_fifo.fifo_empty,
                          dut.port1_i.port_fifo.fifo_empty, dut.port0_i.port_fifo.fifo_empty};

    int vectors = 0;
    int misc    = 0;

    ment_t      mq [4][$];
    logic [1:0] mptr [4];
    cyc_t       exp_q [$];
    int         drop0 = 0;
    int         got0  = 0;
    int         max0  = 0;
    int         seen [4];
    int         ord3 [$];

    // Reference model, advanced once per rising edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        cyc_t       e;
        int         pre [4];
        logic [3:0] clr [4];
        logic       found;
        int         idx;
        ment_t      h;
        e = '0;
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                mq[p].delete();
                mptr[p] = 2'd0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                pre[p] = mq[p].size();
                clr[p] = 4'b0;
            end
            for (int j = 0; j < 4; j++) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    idx = (int'(mptr[j]) + k) % 4;
                    if (!found && mq[idx].size() != 0 && mq[idx][0].pend[j]) begin
                        found      = 1'b1;
                        e[j].valid = 1'b1;
                        e[j].pkt   = mq[idx][0].pkt;
                        clr[idx][j] = 1'b1;
                    end
                    if (found && k == 3) begin
                        mptr[j] = 2'(e[j].pkt.source + 2'd1);
                    end
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (clr[p] != 4'b0) begin
                    h = mq[p][0];
                    h.pend = h.pend & ~clr[p];
                    if (h.pend == 4'b0) mq[p].delete(0);
                    else mq[p][0] = h;
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (vin[p] && tin[p] != 4'b0) begin
                    if (pre[p] < DEPTH) begin
                        h.pkt  = '{source: sin[p], target: tin[p], data: din[p]};
                        h.pend = tin[p];
                        mq[p].push_back(h);
                    end else if (p == 0) begin
                        drop0 += $countones(tin[p]);
                    end
                end
            end
        end
        exp_q.push_back(e);
    end

    // Scoreboard: one expected entry per rising edge, compared on the falling edge.
    always @(negedge clk) begin
        cyc_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int j = 0; j < 4; j++) begin
                vectors++;
                assert (obs[j] === e[j]) else begin
                    misc++;
                    $error("FAIL out%0d observed=%h expected=%h", j, obs[j], e[j]);
                end
                vectors++;
                assert (cnt[j] === 4'(mq[j].size())) else begin
                    misc++;
                    $error("FAIL count%0d observed=%0d expected=%0d", j, cnt[j], mq[j].size());
                end
                vectors++;
                assert ({full_flags[j], empty_flags[j]} ===
                        {mq[j].size() == DEPTH, mq[j].size() == 0}) else begin
                    misc++;
                    $error("FAIL flags%0d observed=%b%b expected=%b%b", j, full_flags[j],
                           empty_flags[j], mq[j].size() == DEPTH, mq[j].size() == 0);
                end
                if (obs[j].valid) seen[j]++;
            end
            if (obs[1].valid && obs[1].pkt.source == 2'd0) got0++;
            if (obs[3].valid) ord3.push_back(int'(obs[3].pkt.source));
            if (int'(cnt[0]) > max0) max0 = int'(cnt[0]);
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            misc++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [3:0] t, input logic [7:0] d);
        vin[p] = 1'b1;
        tin[p] = t;
        din[p] = d;
    endtask

    task automatic clear_seen();
        for (int p = 0; p < 4; p++) seen[p] = 0;
        ord3.delete();
    endtask

    task automatic reset_pulse();
        vin   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vin = '0;
        for (int p = 0; p < 4; p++) begin
            sin[p]  = 2'(p);
            tin[p]  = 4'b0;
            din[p]  = 8'h00;
            seen[p] = 0;
        end
        repeat (3) tick();
        for (int p = 0; p < 4; p++) begin
            check("reset_count", int'(cnt[p]), 0);
            check("reset_valid", int'(obs[p]), 0);
        end
        check("reset_empty", int'(empty_flags), 15);
        rst_n = 1'b1;
        tick();

        // Unicast port0 -> port2.
        clear_seen();
        put(0, 4'b0100, 8'hA5);
        tick();
        vin = '0;
        repeat (2) tick();
        check("t1_copies_p2", seen[2], 1);
        check("t1_idle_p0", seen[0] + seen[1] + seen[3], 0);
        for (int p = 0; p < 4; p++) check("t1_empty", int'(cnt[p]), 0);

        // Broadcast from port1: held until all four copies leave.
        clear_seen();
        put(1, 4'b1111, 8'h3C);
        tick();
        vin = '0;
        check("t2_held", int'(cnt[1]), 1);
        tick();
        check("t2_popped", int'(cnt[1]), 0);
        tick();
        for (int p = 0; p < 4; p++) check("t2_one_copy", seen[p], 1);

        // Four sources into port3 from a fresh arbiter.
        reset_pulse();
        clear_seen();
        for (int p = 0; p < 4; p++) put(p, 4'b1000, 8'(8'h10 + p));
        tick();
        vin = '0;
        repeat (6) tick();
        check("t3_copies", seen[3], 4);
        for (int k = 0; k < 4; k++) check("t3_order", (ord3.size() > k) ? ord3[k] : -1, k);

        // Port0 floods port1 while ports 1-3 keep contending for it.
        reset_pulse();
        drop0 = 0;
        got0  = 0;
        max0  = 0;
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 4; p++) begin
                vin[p] = (p != 0) || (c < 12);
                tin[p] = 4'b0010;
                din[p] = 8'(16 * p + c);
            end
            tick();
        end
        vin = '0;
        repeat (70) tick();
        check("t4_max_le_depth", int'(max0 <= 8), 1);
        check("t4_delivered_plus_dropped", got0 + drop0, 12);

        // Reset with traffic queued toward port3.
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 3; p++) put(p, 4'b1000, 8'(8'h40 + 4 * c + p));
            tick();
        end
        vin   = '0;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            check("t5_count_now", int'(cnt[p]), 0);
            check("t5_out_now", int'(obs[p]), 0);
        end
        tick();
        rst_n = 1'b1;
        clear_seen();
        repeat (10) tick();
        for (int p = 0; p < 4; p++) check("t5_no_stale", seen[p], 0);

        // Zero target mask is ignored.
        clear_seen();
        put(2, 4'b0000, 8'h77);
        tick();
        vin = '0;
        repeat (3) tick();
        check("t6_count", int'(cnt[2]), 0);
        check("t6_no_out", seen[0] + seen[1] + seen[2] + seen[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule

// File: doc/switch_4port.md
# switch_4port

Four-port, single-beat packet switch with multicast. Each port owns an input FIFO (depth 8) and an output register. A packet entering any port is delivered, as an unchanged copy, to every port selected by its 4-bit target mask. A packet offered while its ingress FIFO is full is dropped in full. The block is the top-level DUT of the switch subsystem and connects to four `port_if` interface instances.

## Interface
- `DEPTH`, 8: entries per ingress FIFO.
- `DATA_W`, 8: payload width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `port0`..`port3`  port_if  —  one interface per port.
  - Interface ports: `clk`, `rst_n`.
  - Inputs to the switch: `valid_in` (1), `source_in` (2), `target_in` (4, bit i selects port i), `data_in` (DATA_W).
  - Outputs from the switch: `valid_out` (1), `source_out` (2), `target_out` (4), `data_out` (DATA_W).

## Operation
- Ingress:
  - A packet is written when `valid_in`=1 and `fifo_full`=0 at a clock edge.
  - If `valid_in`=1 and `fifo_full`=1, the packet is dropped silently. This applies even if a pop occurs on the same edge.
  - A packet with `target_in`=0 is never written.
- Each FIFO entry stores `{source, target, data}` plus a pending mask, initialised to `target`.
- Every output port has its own round-robin arbiter over the 4 FIFO heads.
  - A head is a candidate for output j when the FIFO is non-empty and pending[j]=1.
  - After a grant, the pointer moves to the granted index +1 (mod 4).
- A granted output j registers `valid_out`=1 with the head's `source`, `target` and `data`, then clears pending[j] of that head.
- A head is popped on the edge where its last pending bit clears. Multiple outputs may clear bits of the same head on the same edge.
- Loopback (a target bit equal to the own port) is legal and delivered normally.
- There is no output backpressure. `valid_out` is a one-cycle pulse per delivered copy.
- The FIFO count tracks simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Hierarchy is fixed:
  - Per-port instances are `port0_i`..`port3_i`.
  - Each contains instance `port_fifo` exposing `fifo_full`, `fifo_empty` and `fifo_count` (0..DEPTH, width $clog2(DEPTH)+1).

## Timing
- Reset (async assert, sync release):
  - all FIFOs empty: `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0;
  - all `valid_out`=0, `source_out`/`target_out`/`data_out`=0;
  - arbiter pointers=0.
- Reset mid-operation discards every queued packet immediately.
- `fifo_full`/`fifo_empty` are combinational from `fifo_count`.
- Latency:
  - a packet written at edge N can appear on `valid_out` after edge N+1;
  - single-target copies in an idle switch always do.
- Output throughput: at most one packet per output per cycle.
- Each FIFO head is held until all its targets are served. This is intentional head-of-line blocking.
- Fairness: with k contenders for one output, each is granted within k cycles.

## Structure
- Shared package `switch_pkg`:
  - `packet_t` struct `{source, target, data}`;
  - constants `NUM_PORTS`=4, `DEPTH`, `DATA_W`.
- `port_if` is a separate interface file.
- Sub-module `port_fifo`: synchronous FIFO with count/full/empty. It is wrapped per port (with the pending mask) as `switch_port`, instantiated as `port0_i`..`port3_i`.
- Output arbiters and crossbar stay in the top level.

## Test plan
- Reset, then port0 sends data 0xA5, target 4'b0100 → port2 shows `valid_out` for one cycle with data 0xA5, source 0, target 4'b0100; other ports idle; all FIFOs empty afterwards.
- Port1 sends data 0x3C, target 4'b1111 → exactly one copy on each of ports 0–3; port1 FIFO pops only after the 4th copy.
- Ports 0–3 each send one packet to port3 on the same cycle → port3 emits 4 packets on 4 consecutive cycles in round-robin order 0,1,2,3.
- Port0 sends 12 back-to-back packets to port1 while port1's output is also contended → `fifo_count` never exceeds 8. With the contention steady, each packet sent while `fifo_full`=1 is absent at the output. Delivered count + dropped count (popcount of target) = 12.
- Pulse `rst_n` low with 5 packets queued → FIFOs empty and outputs 0 immediately. No queued packets are delivered after release.
- `target_in`=0 → nothing written, `fifo_count` unchanged, no output.
